// File: rtl/processor_core.sv
`default_nettype none
// ============================================================================
// Module   : processor_core
// Purpose  : 16-bit 3-stage (IF / ID / EX) in-order core with a request/ready
//            data-memory port and a sticky powerdown on HALT.
//            Define PROCESSOR_MUL_EN to make opcode 0100 a 16x16 multiply.
// Revision : 1.0 - initial release
// ============================================================================
module processor_core (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  instr_addr,
    input  logic [15:0] instr,
    output logic [7:0]  memAddrLoadStore,
    output logic [15:0] memStoreVal,
    input  logic [15:0] memLoadVal,
    input  logic        valueReady,
    output logic        readReq,
    output logic        writeReq,
    output logic        powerdown
);

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_LD_ARM  = 3'd1,
        S_LD_WAIT = 3'd2,
        S_ST_REQ  = 3'd3,
        S_HALT    = 3'd4
    } ex_state_t;

    localparam logic [3:0] c_OP_NOP   = 4'h0;
    localparam logic [3:0] c_OP_HALT  = 4'h1;
    localparam logic [3:0] c_OP_ADD   = 4'h2;
    localparam logic [3:0] c_OP_SUB   = 4'h3;
    localparam logic [3:0] c_OP_MUL   = 4'h4;
    localparam logic [3:0] c_OP_AND   = 4'h5;
    localparam logic [3:0] c_OP_OR    = 4'h6;
    localparam logic [3:0] c_OP_XOR   = 4'h7;
    localparam logic [3:0] c_OP_NAND  = 4'h8;
    localparam logic [3:0] c_OP_NOR   = 4'h9;
    localparam logic [3:0] c_OP_XNOR  = 4'hA;
    localparam logic [3:0] c_OP_LOAD  = 4'hE;
    localparam logic [3:0] c_OP_STORE = 4'hF;

    logic [7:0]  pc_q;
    logic [7:0]  pc_d;
    logic [15:0] ifid_q;
    logic [3:0]  ex_op_q;
    logic [3:0]  ex_rd_q;
    logic [15:0] ex_a_q;
    logic [15:0] ex_b_q;
    ex_state_t   ex_state_q;
    logic        rd_req_q;
    logic        wr_req_q;
    logic        pwr_q;
    logic [7:0]  mem_addr_q;
    logic [15:0] mem_data_q;
    logic [15:0] rf_q [16];

    logic [3:0]  w_id_op;
    logic [3:0]  w_rs1;
    logic [3:0]  w_rs2;
    logic [15:0] w_rs1_val;
    logic [15:0] w_rs2_val;
    logic        w_load_done;
    logic        w_stall;
    logic        w_advance;
    logic        w_alu_op;
    logic [15:0] w_alu;
    logic        w_wb_en;
    logic [15:0] w_wb_data;

    assign w_id_op = ifid_q[15:12];
    assign w_rs1   = ifid_q[7:4];
    assign w_rs2   = ifid_q[3:0];
    assign pc_d    = pc_q + 8'd1;

    always_comb begin
        w_alu    = '0;
        w_alu_op = 1'b1;
        case (ex_op_q)
            c_OP_ADD:  w_alu = ex_a_q + ex_b_q;
            c_OP_SUB:  w_alu = ex_a_q - ex_b_q;
`ifdef PROCESSOR_MUL_EN
            c_OP_MUL:  w_alu = ex_a_q * ex_b_q;
`endif
            c_OP_AND:  w_alu = ex_a_q & ex_b_q;
            c_OP_OR:   w_alu = ex_a_q | ex_b_q;
            c_OP_XOR:  w_alu = ex_a_q ^ ex_b_q;
            c_OP_NAND: w_alu = ~(ex_a_q & ex_b_q);
            c_OP_NOR:  w_alu = ~(ex_a_q | ex_b_q);
            c_OP_XNOR: w_alu = ~(ex_a_q ^ ex_b_q);
            default:   w_alu_op = 1'b0;
        endcase
    end

    // A load retires on the edge where its request meets ready; the
    // instruction waiting in ID advances on that same edge.
    assign w_load_done = (ex_state_q == S_LD_WAIT) && valueReady;
    assign w_stall     = (ex_state_q != S_RUN) && !w_load_done;
    assign w_advance   = !w_stall;

    assign w_wb_en   = w_load_done || ((ex_state_q == S_RUN) && w_alu_op);
    assign w_wb_data = w_load_done ? memLoadVal : w_alu;

    assign w_rs1_val = (w_wb_en && (ex_rd_q == w_rs1)) ? w_wb_data : rf_q[w_rs1];
    assign w_rs2_val = (w_wb_en && (ex_rd_q == w_rs2)) ? w_wb_data : rf_q[w_rs2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else if (w_wb_en) begin
            rf_q[ex_rd_q] <= w_wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= '0;
            ifid_q     <= {c_OP_NOP, 12'h000};
            ex_op_q    <= c_OP_NOP;
            ex_rd_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_state_q <= S_RUN;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            pwr_q      <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else if (w_advance) begin
            pc_q     <= pc_d;
            ifid_q   <= instr;
            ex_op_q  <= w_id_op;
            ex_rd_q  <= ((w_id_op == c_OP_LOAD) || (w_id_op == c_OP_STORE)) ?
                        ifid_q[3:0] : ifid_q[11:8];
            ex_a_q   <= w_rs1_val;
            ex_b_q   <= w_rs2_val;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            case (w_id_op)
                c_OP_LOAD: begin
                    ex_state_q <= S_LD_ARM;
                    mem_addr_q <= ifid_q[11:4];
                end
                c_OP_STORE: begin
                    ex_state_q <= S_ST_REQ;
                    wr_req_q   <= 1'b1;
                    mem_addr_q <= ifid_q[11:4];
                    mem_data_q <= w_rs2_val;
                end
                c_OP_HALT: begin
                    ex_state_q <= S_HALT;
                    pwr_q      <= 1'b1;
                end
                default: ex_state_q <= S_RUN;
            endcase
        end else begin
            // Stalled: walk the load/store handshake; S_HALT never leaves.
            case (ex_state_q)
                S_LD_ARM: begin
                    ex_state_q <= S_LD_WAIT;
                    rd_req_q   <= 1'b1;
                end
                S_ST_REQ: begin
                    ex_state_q <= S_RUN;
                    wr_req_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign instr_addr       = pc_q;
    assign memAddrLoadStore = mem_addr_q;
    assign memStoreVal      = mem_data_q;
    assign readReq          = rd_req_q;
    assign writeReq         = wr_req_q;
    assign powerdown        = pwr_q;

endmodule
`default_nettype wire

// File: tb/tb_processor_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_processor_core
// Purpose  : Randomised and directed programs for processor_core, checked by an
//            instruction-level reference model through a store scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_processor_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  instr_addr;
    logic [15:0] instr;
    logic [7:0]  memAddrLoadStore;
    logic [15:0] memStoreVal;
    logic [15:0] memLoadVal = '0;
    logic        valueReady = 1'b0;
    logic        readReq;
    logic        writeReq;
    logic        powerdown;

    processor_core dut (
        .clk              (clk),
        .rst              (rst),
        .instr_addr       (instr_addr),
        .instr            (instr),
        .memAddrLoadStore (memAddrLoadStore),
        .memStoreVal      (memStoreVal),
        .memLoadVal       (memLoadVal),
        .valueReady       (valueReady),
        .readReq          (readReq),
        .writeReq         (writeReq),
        .powerdown        (powerdown)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } st_t;

    logic [15:0] imem      [256];
    logic [15:0] dmem      [256];
    logic [15:0] dmem_init [256];
    logic [15:0] prog      [$];
    st_t         exp_q     [$];

    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_writes = 0;
    int    ld_cnt   = 0;
    int    ld_delay = 0;
    int    ld_fixed = 0;
    bit    ld_rand  = 1'b1;
    int    rd_len   = 0;
    int    last_rd_len = 0;
    bit    prev_wr  = 1'b0;
    bit    prev_stall = 1'b0;
    bit    rst_pulse = 1'b0;
    logic [7:0] prev_pc = '0;
    string cur_test = "init";

    assign instr = imem[instr_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL [%s] %s: got %0h, expected %0h", cur_test, name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [3:0] rd,
                                          input logic [3:0] a, input logic [3:0] b);
        return {op, rd, a, b};
    endfunction

    function automatic logic [15:0] enc_m(input logic [3:0] op, input logic [7:0] addr,
                                          input logic [3:0] r);
        return {op, addr, r};
    endfunction

    // Instruction-set interpreter: sequential semantics, no notion of pipeline.
    task automatic run_model();
        logic [15:0] r [16];
        logic [15:0] m [256];
        logic [15:0] ins;
        logic [15:0] a;
        logic [15:0] b;
        int pc;
        for (int i = 0; i < 16; i++) r[i] = '0;
        for (int i = 0; i < 256; i++) m[i] = dmem_init[i];
        exp_q.delete();
        pc = 0;
        for (int step = 0; step < 256; step++) begin
            ins = imem[pc];
            a   = r[ins[7:4]];
            b   = r[ins[3:0]];
            if (ins[15:12] == 4'h1) break;
            case (ins[15:12])
                4'h2: r[ins[11:8]] = a + b;
                4'h3: r[ins[11:8]] = a - b;
`ifdef PROCESSOR_MUL_EN
                4'h4: r[ins[11:8]] = a * b;
`endif
                4'h5: r[ins[11:8]] = a & b;
                4'h6: r[ins[11:8]] = a | b;
                4'h7: r[ins[11:8]] = a ^ b;
                4'h8: r[ins[11:8]] = ~(a & b);
                4'h9: r[ins[11:8]] = ~(a | b);
                4'hA: r[ins[11:8]] = ~(a ^ b);
                4'hE: r[ins[3:0]] = m[ins[11:4]];
                4'hF: begin
                    m[ins[11:4]] = r[ins[3:0]];
                    exp_q.push_back('{addr: ins[11:4], data: r[ins[3:0]]});
                end
                default: ;
            endcase
            pc = (pc + 1) % 256;
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) imem[i] = (i < prog.size()) ? prog[i] : 16'h0000;
    endtask

    task automatic run_prog(input string name, input int max_cycles);
        int cyc;
        logic [7:0] pc_halt;
        cur_test = name;
        @(negedge clk);
        #1 rst = 1'b0;
        load_prog();
        for (int i = 0; i < 256; i++) dmem[i] = dmem_init[i];
        run_model();
        n_writes = 0;
        last_rd_len = 0;
        @(negedge clk);
        #1 rst = 1'b1;
        cyc = 0;
        while (!powerdown && cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
        end
        check("powerdown", {31'd0, powerdown}, 32'd1);
        pc_halt = instr_addr;
        repeat (4) begin
            @(negedge clk);
            check("halt_pc_frozen", {24'd0, instr_addr}, {24'd0, pc_halt});
            check("halt_req_idle", {30'd0, readReq, writeReq}, 32'd0);
        end
        check("stores_outstanding", exp_q.size(), 32'd0);
    endtask

    initial forever begin
        @(negedge rst);
        rst_pulse = 1'b1;
    end

    // Monitor: scoreboard for stores, PC hold during load wait, and the
    // data-memory responder (valueReady after ld_delay cycles of readReq).
    initial forever begin
        @(negedge clk);
        if (rst && writeReq && !prev_wr) begin
            dmem[memAddrLoadStore] = memStoreVal;
            n_writes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL [%s] store_unexpected: addr %0h data %0h, no store expected",
                         cur_test, memAddrLoadStore, memStoreVal);
            end else begin
                st_t e;
                e = exp_q.pop_front();
                check("store_addr", {24'd0, memAddrLoadStore}, {24'd0, e.addr});
                check("store_data", {16'd0, memStoreVal}, {16'd0, e.data});
            end
        end
        if (prev_stall && rst && !rst_pulse)
            check("pc_hold_load", {24'd0, instr_addr}, {24'd0, prev_pc});
        rst_pulse = 1'b0;
        prev_wr = writeReq;
        prev_pc = instr_addr;
        if (readReq) begin
            rd_len++;
            if (ld_cnt >= ld_delay) begin
                valueReady = 1'b1;
                memLoadVal = dmem[memAddrLoadStore];
            end else begin
                valueReady = 1'b0;
                memLoadVal = 16'($urandom);
            end
            ld_cnt++;
        end else begin
            if (rd_len != 0) last_rd_len = rd_len;
            rd_len     = 0;
            ld_cnt     = 0;
            ld_delay   = ld_rand ? int'($urandom_range(0, 3)) : ld_fixed;
            valueReady = 1'($urandom);
            memLoadVal = 16'($urandom);
        end
        prev_stall = rst && readReq && !valueReady;
    end

    initial begin
        logic [15:0] c_logic [6];
        int cyc;
        int n;
        logic [3:0] op;
        c_logic = '{16'h00F0, 16'h0FF0, 16'h0F00, 16'hFF0F, 16'hF00F, 16'hF0FF};
        for (int i = 0; i < 256; i++) begin
            imem[i] = '0;
            dmem[i] = '0;
            dmem_init[i] = '0;
        end

        cur_test = "reset";
        #12;
        check("rst_instr_addr", {24'd0, instr_addr}, 32'd0);
        check("rst_mem_addr", {24'd0, memAddrLoadStore}, 32'd0);
        check("rst_store_val", {16'd0, memStoreVal}, 32'd0);
        check("rst_reqs", {29'd0, readReq, writeReq, powerdown}, 32'd0);

        // Load/add/store/halt, loads answered with a 3-cycle ready delay.
        ld_rand = 1'b0;
        ld_fixed = 3;
        dmem_init[128] = 16'd1;
        dmem_init[129] = 16'd2;
        prog = '{enc_m(4'hE, 8'd128, 4'd1), enc_m(4'hE, 8'd129, 4'd2),
                 enc_r(4'h2, 4'd3, 4'd2, 4'd1), enc_m(4'hF, 8'd130, 4'd3), 16'h1000};
        run_prog("load_add_store", 500);
        check("one_write", n_writes, 32'd1);
        check("mem130", {16'd0, dmem[130]}, 32'd3);
        check("readreq_len_delay3", last_rd_len, 32'd4);
        ld_rand = 1'b1;

        // Dependent SUB -> STORE, logic ops each followed by a store,
        // and two back-to-back stores.
        dmem_init[10] = 16'd7;
        dmem_init[11] = 16'd3;
        dmem_init[20] = 16'h00F0;
        dmem_init[21] = 16'h0FF0;
        prog = '{enc_m(4'hE, 8'd10, 4'd4), enc_m(4'hE, 8'd11, 4'd5),
                 enc_r(4'h3, 4'd6, 4'd4, 4'd5), enc_m(4'hF, 8'd131, 4'd6),
                 enc_m(4'hE, 8'd20, 4'd9), enc_m(4'hE, 8'd21, 4'd7)};
        for (int k = 0; k < 6; k++) begin
            prog.push_back(enc_r(4'(5 + k), 4'd8, 4'd9, 4'd7));
            prog.push_back(enc_m(4'hF, 8'(140 + k), 4'd8));
        end
        prog.push_back(enc_m(4'hF, 8'd150, 4'd9));
        prog.push_back(enc_m(4'hF, 8'd151, 4'd7));
        prog.push_back(16'h1000);
        run_prog("sub_logic_stores", 1000);
        check("mem131_sub", {16'd0, dmem[131]}, 32'd4);
        for (int k = 0; k < 6; k++)
            check("logic_result", {16'd0, dmem[140 + k]}, {16'd0, c_logic[k]});
        check("b2b_store0", {16'd0, dmem[150]}, 32'h00F0);
        check("b2b_store1", {16'd0, dmem[151]}, 32'h0FF0);
        check("write_count", n_writes, 32'd9);

        // Random straight-line programs ending in a full register dump.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 256; i++) dmem_init[i] = 16'($urandom);
            prog.delete();
            n = $urandom_range(20, 50);
            for (int i = 0; i < n; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'h1) op = 4'h2;
                if (op >= 4'hE)
                    prog.push_back(enc_m(op, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15))));
                else
                    prog.push_back(enc_r(op, 4'($urandom), 4'($urandom), 4'($urandom)));
            end
            for (int r = 0; r < 16; r++) prog.push_back(enc_m(4'hF, 8'(240 + r), 4'(r)));
            prog.push_back(16'h1000);
            run_prog("random", 3000);
        end

        // Asynchronous reset in the middle of an outstanding load.
        cur_test = "reset_mid_load";
        ld_rand = 1'b0;
        ld_fixed = 50;
        @(negedge clk);
        #1 rst = 1'b0;
        prog = '{enc_m(4'hE, 8'd128, 4'd1), 16'h1000};
        load_prog();
        exp_q.delete();
        @(negedge clk);
        #1 rst = 1'b1;
        cyc = 0;
        while (!readReq && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("readreq_raised", {31'd0, readReq}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_reqs", {29'd0, readReq, writeReq, powerdown}, 32'd0);
        check("async_rst_addr", {24'd0, memAddrLoadStore}, 32'd0);
        check("async_rst_data", {16'd0, memStoreVal}, 32'd0);
        check("async_rst_pc", {24'd0, instr_addr}, 32'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("restart_pc0", {24'd0, instr_addr}, 32'd0);
        @(negedge clk);
        check("restart_pc1", {24'd0, instr_addr}, 32'd1);
        ld_rand = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/processor_core.md
# processor_core

16-bit, 3-stage in-order pipelined processor: Fetch (IF), Decode/Register-read (ID), Execute/Memory/Writeback (EX). It fetches 16-bit instructions from an 8-bit-addressed instruction port. Loads and stores go through a request/ready data-memory handshake, and the core raises `powerdown` when it executes HALT. It is the top-level compute block, driven by external instruction and data memories.

## Interface
- No parameters.
- `clk  input  1` — single clock; all state updates on rising edge.
- `rst  input  1` — asynchronous, active-low reset.
- `instr_addr  output  8` — PC; address of instruction being fetched.
- `instr  input  16` — instruction word at `instr_addr`, combinationally valid in the same cycle.
- `memAddrLoadStore  output  8` — data address for load/store.
- `memStoreVal  output  16` — store data.
- `memLoadVal  input  16` — load data, valid while `valueReady`=1.
- `valueReady  input  1` — memory indicates `memLoadVal` valid.
- `readReq  output  1` — load request; memory acts on its rising edge.
- `writeReq  output  1` — store request; memory writes on its rising edge.
- `powerdown  output  1` — high once HALT executes; sticky until reset.

## Operation
- Register file: 16 × 16-bit registers R0–R15, all general purpose.
- Reads are write-through: a same-cycle EX writeback to the read register is returned.
- Instruction format: `[15:12]` opcode, `[11:8]` rd, `[7:4]` rs1, `[3:0]` rs2.
- Memory ops use a different layout: `[11:4]` 8-bit address, `[3:0]` register.
- Opcodes:
  - 0000: NOP.
  - 0001: HALT.
  - 0010: ADD, rd = rs1 + rs2.
  - 0011: SUB, rd = rs1 − rs2.
  - 0100: MUL, low 16 bits of the product.
  - 0101: AND.
  - 0110: OR.
  - 0111: XOR.
  - 1000: NAND.
  - 1001: NOR.
  - 1010: XNOR.
  - 1110: LOAD, reg = mem[addr].
  - 1111: STORE, mem[addr] = reg.
  - 1011/1100/1101: execute as NOP.
- Arithmetic: modulo 2^16, no flags.
- PC increments by 1 per fetch, wraps 255 → 0. There are no branches.
- LOAD in EX:
  - Phase 1: `readReq`=1, `memAddrLoadStore`=addr. Pipeline stalls (PC, IF/ID, EX held).
  - Completes at the first rising edge where `readReq`=1 and `valueReady`=1: `memLoadVal` is written to the register and `readReq` returns to 0.
  - `valueReady` is ignored while `readReq`=0.
- STORE in EX occupies 2 cycles:
  - Cycle 1: `writeReq`=1, with `memAddrLoadStore`/`memStoreVal` valid.
  - Cycle 2: `writeReq`=0, address/data held.
  - The pipeline stalls during cycle 1, so back-to-back stores each produce a distinct rising edge.
- HALT reaching EX:
  - `powerdown`=1.
  - PC, pipeline registers and register file freeze.
  - `readReq`/`writeReq` stay 0 until reset.
  - Instructions behind the HALT are discarded.
- Reset (asynchronous, any time, including mid-load/store):
  - PC=0, IF/ID and ID/EX set to NOP, all registers 0.
  - `readReq`=`writeReq`=`powerdown`=0; `memAddrLoadStore`=0, `memStoreVal`=0.
  - On release, fetch restarts at address 0.

## Timing
- Cycle n: `instr_addr`=PC; the edge ending cycle n latches `instr` into IF/ID.
- Cycle n+1: decode and register read; latched into ID/EX.
- Cycle n+2: execute; ALU result is written at the edge ending cycle n+2.
- An instruction may use rd of the immediately preceding instruction with no stall (write-through covers it).
- CPI is 1 for ALU/NOP.
- LOAD occupies EX ≥2 cycles; the minimum of 2 applies when `valueReady` follows `readReq` in the same cycle.
- STORE occupies EX exactly 2 cycles.
- `readReq`, `writeReq`, `memAddrLoadStore`, `memStoreVal` and `powerdown` are decoded only from registered state, giving glitch-free request edges.
- A load followed by a dependent instruction needs no extra stall: the dependent instruction sits in ID until the load writes back.

## Configuration
- `PROCESSOR_MUL_EN` defined: opcode 0100 is a 16×16 multiply keeping the low 16 bits.
- Not defined: 0100 executes as NOP, and no multiplier is synthesized.

## Test plan
- mem[128]=1, mem[129]=2; program `LOAD R1,128; LOAD R2,129; ADD R3,R2,R1; STORE 130,R3; HALT` → exactly one write of 3 to address 130, then `powerdown`=1.
- R4=7, R5=3; `SUB R6,R4,R5; STORE 131,R6` with no NOP between → mem[131]=4. Confirms the dependent ALU→store needs no stall.
- R9=0x00F0, R7=0x0FF0: AND/OR/XOR/NAND/NOR/XNOR R8,R9,R7, each followed by a store → 0x00F0, 0x0FF0, 0x0F00, 0xFF0F, 0xF00F, 0xF0FF.
- Two consecutive STOREs → two separate `writeReq` rising edges with correct address/data on each.
- `valueReady` delayed 3 cycles after `readReq` → PC holds for 3 extra cycles and the load value is correct.
- Reset asserted while `readReq`=1 → all outputs 0 immediately; after release, `instr_addr`=0, then 1.
